// File: rtl/divmod_unit10.sv
// 32-by-16 unsigned restoring divider, one quotient bit per cycle.
// Valid/ready handshakes on both sides; a zero divisor short-circuits straight to DONE.
module divmod_unit10 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] shreg_q, shreg_d;
  logic [16:0] prem_q, prem_d;
  logic [15:0] divisor_q, divisor_d;
  logic [31:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic        div_zero_q, div_zero_d;
  logic        out_valid_q, out_valid_d;

  logic [16:0] trial;
  logic [16:0] trial_diff;
  logic        qbit;

  // The 17-bit trial keeps the shifted-out MSB so divisors >= 16'h8000 compare correctly.
  assign trial      = {prem_q[15:0], shreg_q[31]};
  assign trial_diff = trial - {1'b0, divisor_q};
  assign qbit       = (trial >= {1'b0, divisor_q});

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    prem_d      = prem_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor != 16'd0) begin
            shreg_d    = dividend;
            prem_d     = 17'd0;
            count_d    = 5'd0;
            divisor_d  = divisor;
            div_zero_d = 1'b0;
            state_d    = CALC;
          end else begin
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = dividend[15:0];
            div_zero_d  = 1'b1;
            state_d     = DONE;
          end
        end
      end
      CALC: begin
        shreg_d = {shreg_q[30:0], qbit};
        prem_d  = qbit ? trial_diff : trial;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          quotient_d  = shreg_d;
          remainder_d = prem_d[15:0];
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 5'd0;
      shreg_q     <= 32'd0;
      prem_q      <= 17'd0;
      divisor_q   <= 16'd0;
      quotient_q  <= 32'd0;
      remainder_q <= 16'd0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      prem_q      <= prem_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
